// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline MEM stage.
package pipe_pkg;

    localparam int   XLEN        = 32;
    localparam int   REG_W       = 5;
    localparam int   ADDR_IO_BIT = 7;

    // Word offsets inside the I/O region, selected by address bit 2.
    localparam logic IO_WORD0 = 1'b0;
    localparam logic IO_WORD1 = 1'b1;

    // Which source drives the registered load data.
    typedef enum logic [1:0] {
        WMO_ZERO = 2'd0,
        WMO_RAM  = 2'd1,
        WMO_IO   = 2'd2
    } wmo_src_e;

    // Word accesses must have the two low byte-address bits clear.
    function automatic logic misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/pipe_dram.sv
// Single-port synchronous data RAM, read-first: a write and a read of the
// same word on one edge returns the old contents. No reset on the array.
module pipe_dram
    import pipe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] mem [0:(2**DEPTH_LOG2)-1];

    // Registered read of the old word, optional write of the new one.
    always_ff @(posedge clock) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: data-RAM / memory-mapped I/O access and the MEM/WB register.
// Optional I/O region enabled by defining PIPE_MEM_IO_EN.
module pipe_mem_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int IO_BIT     = ADDR_IO_BIT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mwmem,
    input  logic [XLEN-1:0]  malu,
    input  logic [XLEN-1:0]  mb,
    input  logic [REG_W-1:0] mrn,
    input  logic [XLEN-1:0]  in_port0,
    input  logic [XLEN-1:0]  in_port1,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [XLEN-1:0]  wmo,
    output logic [XLEN-1:0]  walu,
    output logic [REG_W-1:0] wrn,
    output logic             wfault,
    output logic [XLEN-1:0]  out_port0,
    output logic [XLEN-1:0]  out_port1
);

    logic                  is_mem;
    logic                  fault;
    logic                  io_acc;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [XLEN-1:0]       ram_rdata;
    logic [XLEN-1:0]       io_rd_q;
    wmo_src_e              src_d;
    wmo_src_e              src_q;

    assign is_mem  = mwmem | mm2reg;
    assign fault   = is_mem & misaligned(malu[1:0]);
    // Upper address bits are ignored: the RAM aliases every 2**DEPTH_LOG2 words.
    assign ram_idx = malu[DEPTH_LOG2+1:2];

`ifdef PIPE_MEM_IO_EN
    assign io_acc = is_mem & malu[IO_BIT];
`else
    assign io_acc = 1'b0;
`endif

    // Store suppressed on fault, on I/O accesses and while reset is asserted.
    assign ram_we = resetn & mwmem & ~fault & ~io_acc;

    pipe_dram #(.DEPTH_LOG2(DEPTH_LOG2)) u_dram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (mb),
        .rdata (ram_rdata)
    );

    // Pick the next load-data source; faults force zero.
    always_comb begin
        src_d = WMO_RAM;
        if (fault)
            src_d = WMO_ZERO;
        else if (io_acc)
            src_d = WMO_IO;
    end

    // MEM/WB boundary register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            walu   <= '0;
            wrn    <= '0;
            wfault <= 1'b0;
            src_q  <= WMO_ZERO;
        end else begin
            wwreg  <= mwreg & ~fault;
            wm2reg <= mm2reg;
            walu   <= malu;
            wrn    <= mrn;
            wfault <= fault;
            src_q  <= src_d;
        end
    end

    // The RAM read data is already registered inside pipe_dram, so wmo is a
    // registered source selected by a registered select.
    always_comb begin
        unique case (src_q)
            WMO_RAM: wmo = ram_rdata;
            WMO_IO:  wmo = io_rd_q;
            default: wmo = '0;
        endcase
    end

`ifdef PIPE_MEM_IO_EN
    // Sample the addressed input port for I/O loads.
    always_ff @(posedge clock) begin
        if (!resetn)
            io_rd_q <= '0;
        else
            io_rd_q <= (malu[2] == IO_WORD1) ? in_port1 : in_port0;
    end

    // Output port registers written by aligned I/O stores.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
        end else if (mwmem && io_acc && !fault) begin
            if (malu[2] == IO_WORD0)
                out_port0 <= mb;
            else
                out_port1 <= mb;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{malu[XLEN-1:DEPTH_LOG2+2]};
`else
    assign io_rd_q   = '0;
    assign out_port0 = '0;
    assign out_port1 = '0;

    // Input ports and upper address bits have no function in this build.
    logic unused_bits;
    assign unused_bits = ^{in_port0, in_port1, malu[XLEN-1:DEPTH_LOG2+2]};
`endif

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage; I/O checks compiled in with PIPE_MEM_IO_EN.
module tb_pipe_mem_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic [31:0] in_port0, in_port1;
    logic        wwreg, wm2reg, wfault;
    logic [31:0] wmo, walu, out_port0, out_port1;
    logic [4:0]  wrn;

    int total = 0;
    int bad   = 0;
    logic [31:0] w0_exp;

    pipe_mem_stage #(.DEPTH_LOG2(5), .IO_BIT(7)) dut (
        .clock(clock), .resetn(resetn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .in_port0(in_port0), .in_port1(in_port1),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
        .wrn(wrn), .wfault(wfault),
        .out_port0(out_port0), .out_port1(out_port1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one instruction, clock it, sample 1 time unit after the edge.
    task automatic op(input logic wr, input logic ld, input logic st,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] rn);
        mwreg = wr; mm2reg = ld; mwmem = st; malu = a; mb = d; mrn = rn;
        @(posedge clock);
        #1;
    endtask

    initial begin
        in_port0 = 32'h0; in_port1 = 32'h0;

        // Reset with a store pending: outputs zero, store not performed.
        resetn = 1'b0;
        op(1, 0, 1, 32'h4, 32'hAA, 5'd7);
        op(1, 0, 1, 32'h4, 32'hAA, 5'd7);
        chk("rst_wwreg",  {31'b0, wwreg},  32'h0);
        chk("rst_wm2reg", {31'b0, wm2reg}, 32'h0);
        chk("rst_wmo",    wmo,             32'h0);
        chk("rst_walu",   walu,            32'h0);
        chk("rst_wrn",    {27'b0, wrn},    32'h0);
        chk("rst_wfault", {31'b0, wfault}, 32'h0);
        chk("rst_out0",   out_port0,       32'h0);
        chk("rst_out1",   out_port1,       32'h0);
        resetn = 1'b1;
        op(1, 1, 0, 32'h4, 32'h0, 5'd1);
        chk("rst_nostore", {31'b0, wmo != 32'hAA}, 32'h1);

        // Store then load the same word on the next cycle.
        op(0, 0, 1, 32'h8, 32'hDEADBEEF, 5'd0);
        op(1, 1, 0, 32'h8, 32'h0, 5'd3);
        chk("ld_wmo",    wmo,             32'hDEADBEEF);
        chk("ld_wrn",    {27'b0, wrn},    32'h3);
        chk("ld_wwreg",  {31'b0, wwreg},  32'h1);
        chk("ld_wm2reg", {31'b0, wm2reg}, 32'h1);
        chk("ld_walu",   walu,            32'h8);

        // Read-first: a store returns the word it overwrites.
        op(0, 0, 1, 32'h8, 32'hCAFEF00D, 5'd0);
        chk("rf_old", wmo, 32'hDEADBEEF);
        op(1, 1, 0, 32'h8, 32'h0, 5'd4);
        chk("rf_new", wmo, 32'hCAFEF00D);

        // Wrap-around: byte address 0x100 aliases word 0.
        op(0, 0, 1, 32'h0,   32'h11, 5'd0);
        op(0, 0, 1, 32'h100, 32'h22, 5'd0);
        op(1, 1, 0, 32'h0,   32'h0,  5'd5);
        chk("wrap", wmo, 32'h22);

        // Misaligned load and store.
        op(0, 0, 1, 32'h4, 32'h44, 5'd0);
        op(1, 1, 0, 32'h6, 32'h0, 5'd6);
        chk("fl_wfault", {31'b0, wfault}, 32'h1);
        chk("fl_wwreg",  {31'b0, wwreg},  32'h0);
        chk("fl_wmo",    wmo,             32'h0);
        op(0, 0, 1, 32'h5, 32'h99, 5'd0);
        chk("fs_wfault", {31'b0, wfault}, 32'h1);
        op(1, 1, 0, 32'h4, 32'h0, 5'd6);
        chk("fs_ram",    wmo,             32'h44);
        chk("fs_clear",  {31'b0, wfault}, 32'h0);

        // Store and load together: store wins, old data returned.
        op(0, 0, 1, 32'hC, 32'h33, 5'd0);
        op(1, 1, 1, 32'hC, 32'h77, 5'd8);
        chk("both_old", wmo, 32'h33);
        op(1, 1, 0, 32'hC, 32'h0, 5'd8);
        chk("both_new", wmo, 32'h77);

        // Store presented during reset is dropped.
        op(0, 0, 1, 32'h10, 32'h66, 5'd0);
        resetn = 1'b0;
        op(0, 0, 1, 32'h10, 32'h55, 5'd0);
        chk("rmid_wmo", wmo, 32'h0);
        resetn = 1'b1;
        op(1, 1, 0, 32'h10, 32'h0, 5'd9);
        chk("rmid_ram", wmo, 32'h66);

        // Store/load at 0x80: I/O region when enabled, aliased RAM word 0 otherwise.
        in_port1 = 32'h1234;
        in_port0 = 32'h0BAD;
        op(0, 0, 1, 32'h80, 32'h5A, 5'd0);
`ifdef PIPE_MEM_IO_EN
        chk("io_out0", out_port0, 32'h5A);
        chk("io_out1", out_port1, 32'h0);
        op(1, 1, 0, 32'h84, 32'h0, 5'd10);
        chk("io_in1",  wmo, 32'h1234);
        op(1, 1, 0, 32'h80, 32'h0, 5'd10);
        chk("io_in0",  wmo, 32'h0BAD);
        w0_exp = 32'h22;
`else
        chk("noio_out0", out_port0, 32'h0);
        w0_exp = 32'h5A;
`endif
        op(1, 1, 0, 32'h0, 32'h0, 5'd11);
        chk("w0", wmo, w0_exp);

        // Back-to-back ALU ops: pass through, no fault, no RAM writes.
        op(1, 0, 0, 32'h1, 32'hFFFF, 5'd12);
        chk("alu1", walu, 32'h1);
        chk("alu1_wwreg", {31'b0, wwreg}, 32'h1);
        op(1, 0, 0, 32'h2, 32'hFFFF, 5'd13);
        chk("alu2", walu, 32'h2);
        chk("alu2_wfault", {31'b0, wfault}, 32'h0);
        op(1, 0, 0, 32'h3, 32'hFFFF, 5'd14);
        chk("alu3", walu, 32'h3);
        chk("alu3_wrn", {27'b0, wrn}, 32'he);
        op(1, 1, 0, 32'h0, 32'h0, 5'd1);
        chk("alu_nowr0", wmo, w0_exp);
        op(1, 1, 0, 32'h8, 32'h0, 5'd1);
        chk("alu_nowr8", wmo, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
